// File: rtl/char_write_scheduler.sv
// Character write scheduler: round-robin arbitration of two requesters into a
// small write FIFO, drained into the char_row bank only during vertical blanking,
// with a bulk-clear sequencer that takes priority over the FIFO.
module char_write_scheduler #(
  parameter int unsigned NUM_ROWS   = 8,
  parameter int unsigned COLS       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_TOTAL    = 525,
  parameter logic [5:0]  CLEAR_CHAR = 6'h3F,
  localparam int unsigned ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ROW_W-1:0]    req0_row,
  input  logic [COL_W-1:0]    req0_col,
  input  logic [5:0]          req0_char,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ROW_W-1:0]    req1_row,
  input  logic [COL_W-1:0]    req1_col,
  input  logic [5:0]          req1_char,
  input  logic [9:0]          ycoor,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic [NUM_ROWS-1:0] wr_en,
  output logic [COL_W-1:0]    wr_col,
  output logic [5:0]          wr_char,
  output logic [CNT_W-1:0]    fifo_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = ROW_W + COL_W + 6;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StClear, StDrain} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              clear_busy_q;
  logic [ROW_W-1:0]  clr_row_q;
  logic [COL_W-1:0]  clr_col_q;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];

  logic              gate;
  logic              push, pop, clr_wr, grant1;
  logic [ENT_W-1:0]  push_data;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [5:0]        rd_char;

  // The last frame line is a guard so a write never lands on the first visible line.
  assign gate = (ycoor >= 10'(V_ACTIVE)) && (ycoor < 10'(V_TOTAL - 1));

  assign fifo_count = count_q;
  assign clear_busy = clear_busy_q;

  // Round-robin grant off the registered count; a full FIFO refuses even if a pop is due.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (count_q < CNT_W'(FIFO_DEPTH))) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant_q;
        req1_ready = !last_grant_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign grant1    = req1_valid && req1_ready;
  assign push      = (req0_valid && req0_ready) || grant1;
  assign push_data = grant1 ? {req1_row, req1_col, req1_char} : {req0_row, req0_col, req0_char};
  assign {rd_row, rd_col, rd_char} = mem[rptr_q];

  // Work is only issued when the gate was open at the decision edge as well.
  assign pop    = (state_q == StDrain) && gate && (count_q != '0);
  assign clr_wr = (state_q == StClear) && gate && clear_busy_q;

  // Next state: clear beats drain while blanking; any pending work outside blanking waits.
  always_comb begin
    state_d = StIdle;
    if (gate) begin
      if (clear_busy_q) begin
        state_d = StClear;
      end else if (count_q != '0) begin
        state_d = StDrain;
      end
    end else if (clear_busy_q || (count_q != '0)) begin
      state_d = StWait;
    end
  end

  // FIFO storage; contents are don't-care until written, pointers carry the reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= push_data;
    end
  end

  // Control state, FIFO pointers, clear walker and registered write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      clear_busy_q <= 1'b0;
      clr_row_q    <= '0;
      clr_col_q    <= '0;
      wr_en        <= '0;
      wr_col       <= '0;
      wr_char      <= '0;
    end else begin
      state_q <= state_d;
      wr_en   <= '0;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wptr_q       <= wptr_q + PTR_W'(1);
        last_grant_q <= grant1;
      end
      if (pop) begin
        rptr_q  <= rptr_q + PTR_W'(1);
        wr_en   <= NUM_ROWS'(1) << rd_row;
        wr_col  <= rd_col;
        wr_char <= rd_char;
      end
      if (clear_start && !clear_busy_q) begin
        clear_busy_q <= 1'b1;
        clr_row_q    <= '0;
        clr_col_q    <= '0;
      end
      if (clr_wr) begin
        wr_en   <= NUM_ROWS'(1) << clr_row_q;
        wr_col  <= clr_col_q;
        wr_char <= CLEAR_CHAR;
        if (clr_col_q == LastCol) begin
          clr_col_q <= '0;
          if (clr_row_q == LastRow) begin
            clr_row_q    <= '0;
            clear_busy_q <= 1'b0;
          end else begin
            clr_row_q <= clr_row_q + ROW_W'(1);
          end
        end else begin
          clr_col_q <= clr_col_q + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_char_write_scheduler.sv
// Directed bench for char_write_scheduler with an in-order write scoreboard.
module tb_char_write_scheduler;

  typedef struct packed {
    logic [2:0] row;
    logic [4:0] col;
    logic [5:0] ch;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_row = '0, req1_row = '0;
  logic [4:0] req0_col = '0, req1_col = '0;
  logic [5:0] req0_char = '0, req1_char = '0;
  logic [9:0] ycoor = 10'd100;
  logic       clear_start = 1'b0;
  logic       clear_busy;
  logic [7:0] wr_en;
  logic [4:0] wr_col;
  logic [5:0] wr_char;
  logic [2:0] fifo_count;

  int  checks = 0;
  int  failures = 0;
  int  wr_count = 0;
  bit  mon_en = 1'b1;
  wr_t exp_q[$];
  wr_t mon_e;

  char_write_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_row   (req0_row),
    .req0_col   (req0_col),
    .req0_char  (req0_char),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_row   (req1_row),
    .req1_col   (req1_col),
    .req1_char  (req1_char),
    .ycoor      (ycoor),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] r, input logic [4:0] c, input logic [5:0] ch);
    wr_t e;
    e.row = r;
    e.col = c;
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int target, input int bound);
    for (int i = 0; i < bound && wr_count < target; i++) tick();
    chk("clear_progress", 32'(wr_count >= target), 1);
  endtask

  // Scoreboard: every strobe seen must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && !rst && (wr_en !== 8'h00)) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(wr_en), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'(8'(1) << mon_e.row));
        chk("wr_col", 32'(wr_col), 32'(mon_e.col));
        chk("wr_char", 32'(wr_char), 32'(mon_e.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, i1, base;

    // Reset with a pending request outside blanking.
    req0_valid = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_col", 32'(wr_col), 0);
    chk("rst_wr_char", 32'(wr_char), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 1);
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_wr_active", 32'(wr_en), 0);
    end

    // Fill the FIFO outside blanking, then drain it in blanking.
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1;
      req0_row   = 3'd2;
      req0_col   = 5'(k);
      req0_char  = 6'(5 + k);
      #1;
      chk("fill_ready0", 32'(req0_ready), 1);
      chk("fill_ready1", 32'(req1_ready), 0);
      push_exp(3'd2, 5'(k), 6'(5 + k));
      tick();
    end
    req0_col  = 5'd4;
    req0_char = 6'd9;
    #1;
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready0", 32'(req0_ready), 0);
    tick();
    chk("full_ready0_hold", 32'(req0_ready), 0);
    req0_valid = 1'b0;
    ycoor = 10'd480;
    tick();
    chk("drain_lat", 32'(wr_en), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_back2back", 32'(wr_en), 32'h04);
    end
    tick();
    chk("drain_end", 32'(wr_en), 0);
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_q", exp_q.size(), 0);

    // Fresh reset so the arbiter starts from last_grant=1, then alternate grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      req0_valid = 1'b1;
      req0_row   = 3'd1;
      req0_col   = 5'(10 + i0);
      req0_char  = 6'(20 + i0);
      req1_valid = 1'b1;
      req1_row   = 3'd3;
      req1_col   = 5'(i1);
      req1_char  = 6'(40 + i1);
      #1;
      chk("rr_ready0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("rr_ready1", 32'(req1_ready), 32'((k % 2) == 1));
      if (k == 2) chk("lat_before", 32'(wr_en), 0);
      if (k == 3) chk("lat_first", 32'(wr_en), 32'h02);
      if ((k % 2) == 0) begin
        push_exp(3'd1, 5'(10 + i0), 6'(20 + i0));
        i0++;
      end else begin
        push_exp(3'd3, 5'(i1), 6'(40 + i1));
        i1++;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain(40);

    // Guard line 524 holds queued writes until the next blanking.
    ycoor = 10'd100;
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1;
      req1_row   = 3'd5;
      req1_col   = 5'(k);
      req1_char  = 6'(30 + k);
      #1;
      chk("guard_ready1", 32'(req1_ready), 1);
      push_exp(3'd5, 5'(k), 6'(30 + k));
      tick();
    end
    req1_valid = 1'b0;
    ycoor = 10'd524;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("guard_no_wr", 32'(wr_en), 0);
    end
    chk("guard_count", 32'(fifo_count), 3);
    ycoor = 10'd480;
    wait_drain(20);

    // Bulk clear with a mid-way pause and a request queued behind it.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 32; c++) push_exp(3'(r), 5'(c), 6'h3F);
    end
    base = wr_count;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clear_busy_set", 32'(clear_busy), 1);
    wait_writes(base + 50, 200);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_writes(base + 100, 200);
    ycoor = 10'd100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("clear_pause", 32'(wr_en), 0);
    end
    chk("clear_busy_pause", 32'(clear_busy), 1);
    req0_valid = 1'b1;
    req0_row   = 3'd7;
    req0_col   = 5'd31;
    req0_char  = 6'h01;
    #1;
    chk("clear_req_ready", 32'(req0_ready), 1);
    push_exp(3'd7, 5'd31, 6'h01);
    tick();
    req0_valid = 1'b0;
    chk("clear_req_count", 32'(fifo_count), 1);
    ycoor = 10'd480;
    wait_drain(400);
    chk("clear_total", wr_count - base, 257);
    chk("clear_busy_done", 32'(clear_busy), 0);
    chk("clear_fifo_empty", 32'(fifo_count), 0);

    // Reset in the middle of a clear with a write also queued.
    mon_en = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    req1_valid = 1'b1;
    req1_row   = 3'd4;
    req1_col   = 5'd4;
    req1_char  = 6'd2;
    tick();
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midclr_busy", 32'(clear_busy), 1);
    chk("midclr_count", 32'(fifo_count), 1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(clear_busy), 0);
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_count", 32'(fifo_count), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("postrst_no_wr", 32'(wr_en), 0);
    end
    chk("postrst_busy", 32'(clear_busy), 0);
    mon_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
